// File: rtl/dac_arb_pkg.sv
// -----------------------------------------------------------------------------
// dac_arb_pkg
// Shared definitions for the DAC update arbiter and related shared-resource
// arbiters in the controller.
//   arb_state_e : arbiter FSM state (IDLE, BUSY)
//   addr_width(): channel-address width needed to address n_chan channels
//                 (never less than 1 bit)
// -----------------------------------------------------------------------------
package dac_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic int addr_width(input int n_chan);
      return (n_chan <= 2) ? 1 : $clog2(n_chan);
   endfunction

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin priority picker. Returns the first set request
// bit at or after ptr_in, wrapping modulo N_REQ.
//   req_in  [N_REQ] : request bits
//   ptr_in  [W_SEL] : highest-priority index this cycle (must be < N_REQ)
//   sel_out [W_SEL] : index of the winning request (0 when none)
//   any_out         : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_select #(
   parameter int N_REQ = 8,
   parameter int W_SEL = 3
) (
   input  logic [N_REQ-1:0] req_in,
   input  logic [W_SEL-1:0] ptr_in,
   output logic [W_SEL-1:0] sel_out,
   output logic             any_out
);

   logic [W_SEL-1:0] idx;

   // Walk the requests starting from the pointer; the first hit wins and
   // any_out then masks all later candidates.
   always_comb begin
      sel_out = '0;
      any_out = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = W_SEL'((int'(ptr_in) + i) % N_REQ);
         if (!any_out && req_in[idx]) begin
            sel_out = idx;
            any_out = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dac_update_arbiter.sv
// -----------------------------------------------------------------------------
// dac_update_arbiter
// Shares the single serial DAC write port among N_CHAN output channels using
// round-robin arbitration. Each channel owns a one-deep latest-wins holding
// register so a slow DAC never stalls the control loops.
//
// Ports
//   clk_in        : system clock
//   n_rst_in      : synchronous active-low reset
//   chan_en_in    : per-channel enable; a disabled channel loses its pending
//                   value and ignores strobes
//   upd_valid_in  : per-channel one-cycle "new value" strobe
//   upd_data_in   : packed data, channel k at [k*W_DATA +: W_DATA]
//   dac_req_out   : write request to the serializer
//   dac_addr_out  : channel being written
//   dac_data_out  : word being written
//   dac_ack_in    : one-cycle pulse from the serializer, write complete
//   pending_out   : holding-register-occupied flags
//   state_dbg_out : current arbiter FSM state
//   drop_cnt_out  : saturating count of overwritten pending values
//                   (only when DAC_ARB_DROP_CNT_EN is defined)
//
// Handshake: dac_req_out rises with a registered (addr, data) word and both
// stay stable until dac_ack_in is sampled high; req drops on that edge and
// stays low for at least one cycle before the next grant. dac_ack_in seen
// while no request is outstanding is ignored.
//
// Optional feature macro: DAC_ARB_DROP_CNT_EN
// -----------------------------------------------------------------------------
module dac_update_arbiter
   import dac_arb_pkg::*;
#(
   parameter int N_CHAN = 8,
   parameter int W_DATA = 16,
   parameter int W_ADDR = addr_width(N_CHAN)
) (
   input  logic                     clk_in,
   input  logic                     n_rst_in,
   input  logic [N_CHAN-1:0]        chan_en_in,
   input  logic [N_CHAN-1:0]        upd_valid_in,
   input  logic [N_CHAN*W_DATA-1:0] upd_data_in,
   output logic                     dac_req_out,
   output logic [W_ADDR-1:0]        dac_addr_out,
   output logic [W_DATA-1:0]        dac_data_out,
   input  logic                     dac_ack_in,
   output logic [N_CHAN-1:0]        pending_out,
   output arb_state_e               state_dbg_out
`ifdef DAC_ARB_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt_out
`endif
);

   arb_state_e        state_q, state_d;
   logic [W_DATA-1:0] hold_q [N_CHAN];
   logic [N_CHAN-1:0] pend_q, pend_d;
   logic [N_CHAN-1:0] strobe, eligible, grant_vec;
   logic [W_ADDR-1:0] rr_ptr_q, pick_sel;
   logic              pick_any, grant, done;

   assign strobe   = upd_valid_in & chan_en_in;
   // A channel disabled this cycle is no longer a candidate for a grant.
   assign eligible = pend_q & chan_en_in;

   rr_select #(
      .N_REQ (N_CHAN),
      .W_SEL (W_ADDR)
   ) u_rr_select (
      .req_in  (eligible),
      .ptr_in  (rr_ptr_q),
      .sel_out (pick_sel),
      .any_out (pick_any)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in) begin
      if (!n_rst_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (dac_ack_in) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_vec = '0;
      if (grant) grant_vec[pick_sel] = 1'b1;
   end

   // A strobe always leaves the flag set, including on the channel being
   // granted this cycle (the granted word is the old hold value).
   assign pend_d = chan_en_in & (strobe | (pend_q & ~grant_vec));

   // ---------------- holding registers ----------------
   always_ff @(posedge clk_in) begin
      if (!n_rst_in) begin
         pend_q <= '0;
         for (int k = 0; k < N_CHAN; k++) hold_q[k] <= '0;
      end else begin
         pend_q <= pend_d;
         for (int k = 0; k < N_CHAN; k++) begin
            if (strobe[k]) hold_q[k] <= upd_data_in[k*W_DATA +: W_DATA];
         end
      end
   end

   // ---------------- output word and round-robin pointer ----------------
   always_ff @(posedge clk_in) begin
      if (!n_rst_in) begin
         dac_addr_out <= '0;
         dac_data_out <= '0;
         rr_ptr_q     <= '0;
      end else if (grant) begin
         dac_addr_out <= pick_sel;
         dac_data_out <= hold_q[pick_sel];
      end else if (done) begin
         // The word just written keeps lowest priority for the next round.
         rr_ptr_q <= (dac_addr_out == W_ADDR'(N_CHAN - 1)) ? '0
                                                          : dac_addr_out + W_ADDR'(1);
      end
   end

   assign dac_req_out   = (state_q == BUSY);
   assign pending_out   = pend_q;
   assign state_dbg_out = state_q;

`ifdef DAC_ARB_DROP_CNT_EN
   // ---------------- dropped-update counter ----------------
   logic [N_CHAN-1:0] drop_vec;
   logic [16:0]       drop_sum;
   logic [15:0]       drop_cnt_q;

   // Overwrite of a still-pending value; the grant-cycle strobe is exempt
   // because the old value is being written out.
   assign drop_vec = strobe & pend_q & ~grant_vec;
   assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(drop_vec));

   always_ff @(posedge clk_in) begin
      if (!n_rst_in)        drop_cnt_q <= '0;
      else if (drop_sum[16]) drop_cnt_q <= 16'hFFFF;
      else                  drop_cnt_q <= drop_sum[15:0];
   end

   assign drop_cnt_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dac_update_arbiter.sv
module tb_dac_update_arbiter;
   import dac_arb_pkg::*;

   localparam int N  = 8;
   localparam int W  = 16;
   localparam int WA = 3;

   // ---------------- clock / reset ----------------
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic             n_rst_in;
   logic [N-1:0]     chan_en_in;
   logic [N-1:0]     upd_valid_in;
   logic [N*W-1:0]   upd_data_in;
   logic             dac_req_out;
   logic [WA-1:0]    dac_addr_out;
   logic [W-1:0]     dac_data_out;
   logic             dac_ack_in;
   logic [N-1:0]     pending_out;
   arb_state_e       state_dbg_out;
`ifdef DAC_ARB_DROP_CNT_EN
   logic [15:0]      drop_cnt_out;
`endif

   dac_update_arbiter #(.N_CHAN(N), .W_DATA(W), .W_ADDR(WA)) dut (
      .clk_in        (clk_in),
      .n_rst_in      (n_rst_in),
      .chan_en_in    (chan_en_in),
      .upd_valid_in  (upd_valid_in),
      .upd_data_in   (upd_data_in),
      .dac_req_out   (dac_req_out),
      .dac_addr_out  (dac_addr_out),
      .dac_data_out  (dac_data_out),
      .dac_ack_in    (dac_ack_in),
      .pending_out   (pending_out),
      .state_dbg_out (state_dbg_out)
`ifdef DAC_ARB_DROP_CNT_EN
      ,
      .drop_cnt_out  (drop_cnt_out)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: per-channel pending slot + current write, at the level
   // of "which word goes out next".
   bit             m_pend [N];
   logic [W-1:0]   m_hold [N];
   bit             m_busy;
   int             m_addr;
   logic [W-1:0]   m_data;
   int             m_ptr;
   int             m_drops;
   int             busy_cnt;
   int             ack_lat = 4;
   logic [N-1:0]   cur_en  = '1;
   logic           prev_req = 1'b0;

   logic [WA+W-1:0] exp_q[$];     // predicted words, in grant order
   logic [WA+W-1:0] grant_log[$]; // words seen at each req rising edge

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_pend[k] = 1'b0;
         m_hold[k] = '0;
      end
      m_busy   = 1'b0;
      m_addr   = 0;
      m_data   = '0;
      m_ptr    = 0;
      m_drops  = 0;
      busy_cnt = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit rst_n, input logic [N-1:0] en, input logic [N-1:0] vld,
                             input logic [N*W-1:0] data, input bit ack);
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (m_pend[c] && en[c]) begin
               m_busy    = 1'b1;
               m_addr    = c;
               m_data    = m_hold[c];
               m_pend[c] = 1'b0;
               exp_q.push_back({WA'(c), m_hold[c]});
               break;
            end
         end
      end else if (ack) begin
         m_busy = 1'b0;
         m_ptr  = (m_addr + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
         if (!en[k]) begin
            m_pend[k] = 1'b0;
         end else if (vld[k]) begin
            if (m_pend[k] && m_drops < 65535) m_drops++;
            m_hold[k] = data[k*W +: W];
            m_pend[k] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0]    exp_pend;
      logic [WA+W-1:0] exp_word;
      for (int k = 0; k < N; k++) exp_pend[k] = m_pend[k];
      check("req", dac_req_out, m_busy);
      check("pending", pending_out, exp_pend);
      if (m_busy) begin
         check("addr", dac_addr_out, m_addr);
         check("data", dac_data_out, m_data);
      end
`ifdef DAC_ARB_DROP_CNT_EN
      check("drop_cnt", drop_cnt_out, m_drops);
`endif
      if (dac_req_out && !prev_req) begin
         grant_log.push_back({dac_addr_out, dac_data_out});
         check("grant_q_size", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            check("grant_word", {dac_addr_out, dac_data_out}, exp_word);
         end
      end
      prev_req = dac_req_out;
   endtask

   // ---------------- driver tasks ----------------
   function automatic logic [N*W-1:0] rand_data();
      logic [N*W-1:0] d;
      for (int i = 0; i < N*W/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Called just after a negedge: drive one cycle, step the model, compare.
   task automatic tick(input bit rst_n, input logic [N-1:0] en, input logic [N-1:0] vld,
                       input logic [N*W-1:0] data, input bit spur);
      bit ack;
      if (m_busy) begin
         busy_cnt++;
         ack = (busy_cnt >= ack_lat);
      end else begin
         ack = spur;
      end
      n_rst_in     = rst_n;
      chan_en_in   = en;
      upd_valid_in = vld;
      upd_data_in  = data;
      dac_ack_in   = ack;
      model_step(rst_n, en, vld, data, ack);
      if (!m_busy) busy_cnt = 0;
      @(negedge clk_in);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, cur_en, '0, rand_data(), 1'b0);
   endtask

   task automatic strobe1(input int ch, input logic [W-1:0] v);
      logic [N*W-1:0] d;
      logic [N-1:0]   m;
      d = rand_data();
      d[ch*W +: W] = v;
      m = '0;
      m[ch] = 1'b1;
      tick(1'b1, cur_en, m, d, 1'b0);
   endtask

   task automatic do_reset();
      tick(1'b0, cur_en, 8'($urandom), rand_data(), 1'b0);
      tick(1'b0, cur_en, 8'($urandom), rand_data(), 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_rst_in     = 1'b0;
      chan_en_in   = '1;
      upd_valid_in = '0;
      upd_data_in  = '0;
      dac_ack_in   = 1'b0;
      model_reset();
      @(negedge clk_in);
      do_reset();
      check("rst_req", dac_req_out, 0);
      check("rst_addr", dac_addr_out, 0);
      check("rst_data", dac_data_out, 0);
      check("rst_pend", pending_out, 0);
      check("rst_state", state_dbg_out, IDLE);

      // Single request, two-cycle latency, ack after 10 cycles
      ack_lat = 10;
      strobe1(2, 16'h1234);
      check("t1_req_edge1", dac_req_out, 0);
      check("t1_pend2", pending_out[2], 1);
      idle(1);
      check("t1_req_edge2", dac_req_out, 1);
      check("t1_addr", dac_addr_out, 2);
      check("t1_data", dac_data_out, 16'h1234);
      check("t1_state", state_dbg_out, BUSY);
      idle(10);
      check("t1_req_after_ack", dac_req_out, 0);
      check("t1_pend_after_ack", pending_out, 0);

      // Round-robin order 0, 3, 5 from a fresh pointer
      do_reset();
      grant_log.delete();
      ack_lat = 3;
      tick(1'b1, cur_en, 8'b0010_1001, rand_data(), 1'b0);
      idle(20);
      check("t2_n", grant_log.size(), 3);
      check("t2_g0", grant_log[0][W +: WA], 0);
      check("t2_g1", grant_log[1][W +: WA], 3);
      check("t2_g2", grant_log[2][W +: WA], 5);

      // Latest wins while busy on ch4
      grant_log.delete();
      ack_lat = 8;
      strobe1(4, 16'h4444);
      idle(1);
      strobe1(1, 16'h0001);
      strobe1(1, 16'h0002);
      idle(20);
      check("t3_n", grant_log.size(), 2);
      check("t3_g1", grant_log[1], {3'd1, 16'h0002});
`ifdef DAC_ARB_DROP_CNT_EN
      check("t3_drops", drop_cnt_out, 1);
`endif

      // Strobe on the grant cycle of the same channel
      grant_log.delete();
      ack_lat = 2;
      strobe1(6, 16'h00AA);
      strobe1(6, 16'h00BB);
      idle(12);
      check("t4_n", grant_log.size(), 2);
      check("t4_g0", grant_log[0], {3'd6, 16'h00AA});
      check("t4_g1", grant_log[1], {3'd6, 16'h00BB});
`ifdef DAC_ARB_DROP_CNT_EN
      check("t4_drops", drop_cnt_out, 1);
`endif

      // Enable mask
      grant_log.delete();
      cur_en = 8'hFE;
      strobe1(0, 16'hBEEF);
      idle(5);
      check("t5_no_req", dac_req_out, 0);
      check("t5_no_pend", pending_out, 0);
      cur_en = 8'hFF;
      ack_lat = 6;
      strobe1(3, 16'h0303);
      idle(1);
      strobe1(7, 16'h0707);
      check("t5_pend7", pending_out[7], 1);
      cur_en = 8'h7F;
      idle(1);
      check("t5_pend7_clr", pending_out[7], 0);
      idle(15);
      cur_en = 8'hFF;
      idle(3);
      check("t5_n", grant_log.size(), 1);
      check("t5_g0", grant_log[0][W +: WA], 3);

      // Reset mid-transfer, then pointer must favour ch0 over ch7
      ack_lat = 20;
      strobe1(5, 16'h5555);
      idle(2);
      check("t6_busy", dac_req_out, 1);
      tick(1'b0, cur_en, 8'($urandom), rand_data(), 1'b0);
      check("t6_req", dac_req_out, 0);
      check("t6_addr", dac_addr_out, 0);
      check("t6_data", dac_data_out, 0);
      check("t6_pend", pending_out, 0);
      grant_log.delete();
      ack_lat = 2;
      tick(1'b1, cur_en, 8'b1000_0001, rand_data(), 1'b0);
      idle(10);
      check("t6_n", grant_log.size(), 2);
      check("t6_g0", grant_log[0][W +: WA], 0);
      check("t6_g1", grant_log[1][W +: WA], 7);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         logic [N-1:0] vld;
         if ($urandom_range(0, 99) == 0)
            cur_en = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         for (int k = 0; k < N; k++) vld[k] = ($urandom_range(0, 7) == 0);
         if (!m_busy) ack_lat = $urandom_range(1, 6);
         tick(($urandom_range(0, 999) != 0), cur_en, vld, rand_data(), ($urandom_range(0, 3) == 0));
      end

      cur_en = 8'hFF;
      idle(120);
      check("drain_pend", pending_out, 0);
      check("drain_exp_q", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
